sprite_shadow_regs: RTL and testbench



---
 rtl/sprite_shadow_regs.sv | 161 ++++++++++++++++
 tb/tb_sprite_shadow_regs.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_shadow_regs.sv
// sprite_shadow_regs: double-buffered sprite/score register bank.
// Software writes a pending bank through the Avalon-MM slave. The pending
// bank is copied to the active bank at the start of vertical blank when a
// commit is armed, or every dirty frame in auto mode. Also provides a
// 16-bit frame counter and a status word for software pacing.
// Optional build macro: SHADOW_READBACK_EN enables read-back of the
// pending bank (0..NREGS-1) and active bank (0x1F2+i).

module sprite_shadow_regs #(
   parameter int unsigned NREGS   = 13,
   parameter int unsigned VACTIVE = 480
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  chipselect,
   input  logic                  write,
   input  logic                  read,
   input  logic [8:0]            address,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [9:0]            vcount,
   output logic [NREGS*8-1:0]    active_regs,
   output logic                  frame_pulse,
   output logic                  commit_done
);

   localparam int unsigned AW  = 9;
   localparam int unsigned DW  = 32;
   localparam int unsigned RW  = 8;
   localparam int unsigned VW  = 10;
   localparam int unsigned FCW = 16;

   localparam logic [AW-1:0] ADDR_CTRL    = 9'h1F0;
   localparam logic [AW-1:0] ADDR_STATUS  = 9'h1F1;
`ifdef SHADOW_READBACK_EN
   localparam logic [AW-1:0] ADDR_ACTIVE0 = 9'h1F2;
`endif

   logic [NREGS*RW-1:0] pending;
   logic                armed;
   logic                dirty;
   logic                auto_mode;
   logic [FCW-1:0]      frame_count;
   logic                vb_q;
   logic                vb_q2;

   logic                wr_c;
   logic                rd_c;
   logic                pend_hit_c;
   logic                ctrl_hit_c;
   logic                vblank_c;
   logic                commit_c;
   logic [DW-1:0]       read_mux_c;
   logic                unused;

   assign wr_c        = chipselect & write;
   assign rd_c        = chipselect & read;
   assign pend_hit_c  = wr_c && (address < AW'(NREGS));
   assign ctrl_hit_c  = wr_c && (address == ADDR_CTRL);
   assign vblank_c    = (vcount >= VW'(VACTIVE));
   assign frame_pulse = vb_q & ~vb_q2;
   assign commit_c    = frame_pulse & (armed | (auto_mode & dirty));
   assign unused      = ^writedata[DW-1:RW];

   // vblank edge detector: two-stage history of the vblank compare
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vb_q  <= 1'b0;
         vb_q2 <= 1'b0;
      end else begin
         vb_q  <= vblank_c;
         vb_q2 <= vb_q;
      end
   end

   // frame counter, free-running modulo 2^16 on each vblank start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_count <= '0;
      end else if (frame_pulse) begin
         frame_count <= frame_count + FCW'(1);
      end
   end

   // pending bank: software writes land here at any time
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < int'(NREGS); i++) begin
            if (wr_c && (address == AW'(i))) begin
               pending[i*RW +: RW] <= writedata[RW-1:0];
            end
         end
      end
   end

   // active bank: whole-bank copy at commit so a frame never tears
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_regs <= '0;
         commit_done <= 1'b0;
      end else begin
         commit_done <= commit_c;
         if (commit_c) begin
            active_regs <= pending;
         end
      end
   end

   // control flags: a write in the commit cycle wins over the commit's clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed     <= 1'b0;
         dirty     <= 1'b0;
         auto_mode <= 1'b0;
      end else begin
         if (commit_c) begin
            armed <= 1'b0;
            dirty <= 1'b0;
         end
         if (pend_hit_c) begin
            dirty <= 1'b1;
         end
         if (ctrl_hit_c) begin
            if (writedata[0]) begin
               armed <= 1'b1;
            end
            auto_mode <= writedata[1];
         end
      end
   end

   // read decode: STATUS always, bank read-back only when built in
   always_comb begin
      read_mux_c = '0;
      if (address == ADDR_STATUS) begin
         read_mux_c = {frame_count, 13'b0, auto_mode, dirty, armed};
      end
`ifdef SHADOW_READBACK_EN
      for (int i = 0; i < int'(NREGS); i++) begin
         if (address == AW'(i)) begin
            read_mux_c = {24'b0, pending[i*RW +: RW]};
         end
         if (address == (ADDR_ACTIVE0 + AW'(i))) begin
            read_mux_c = {24'b0, active_regs[i*RW +: RW]};
         end
      end
`endif
   end

   // read data register: captured on a read strobe, held otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else if (rd_c) begin
         readdata <= read_mux_c;
      end
   end

endmodule

// File: tb/tb_sprite_shadow_regs.sv
// Directed self-checking bench for sprite_shadow_regs.
// Inputs change and outputs are sampled just after the falling edge.

module tb_sprite_shadow_regs;

   localparam int unsigned NREGS = 13;

   logic                 clk;
   logic                 reset;
   logic                 chipselect;
   logic                 write;
   logic                 read;
   logic [8:0]           address;
   logic [31:0]          writedata;
   logic [31:0]          readdata;
   logic [9:0]           vcount;
   logic [NREGS*8-1:0]   active_regs;
   logic                 frame_pulse;
   logic                 commit_done;

   int checks   = 0;
   int failures = 0;
   int fp_cnt   = 0;
   int cd_cnt   = 0;
   logic [31:0] rd;

   sprite_shadow_regs #(.NREGS(NREGS), .VACTIVE(480)) dut (
      .clk         (clk),
      .reset       (reset),
      .chipselect  (chipselect),
      .write       (write),
      .read        (read),
      .address     (address),
      .writedata   (writedata),
      .readdata    (readdata),
      .vcount      (vcount),
      .active_regs (active_regs),
      .frame_pulse (frame_pulse),
      .commit_done (commit_done)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (frame_pulse) fp_cnt++;
      if (commit_done) cd_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      step();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [8:0] a, output logic [31:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      step();
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic sweep_frame();
      for (int v = 0; v < 525; v++) begin
         vcount = 10'(v);
         step();
      end
   endtask

   task automatic vblank();
      vcount = 10'd480;
      repeat (4) step();
      vcount = 10'd0;
      step();
   endtask

   initial begin
      reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = '0; writedata = '0; vcount = '0;
      repeat (3) step();
      check("rst_readdata", 128'(readdata), 128'h0);
      check("rst_active", 128'(active_regs), 128'h0);
      check("rst_pulses", {126'h0, frame_pulse, commit_done}, 128'h0);
      reset = 1'b0;
      step();

      // two idle frames
      sweep_frame();
      sweep_frame();
      check("idle_fp_cnt", 128'(fp_cnt), 128'd2);
      check("idle_cd_cnt", 128'(cd_cnt), 128'd0);
      check("idle_active", 128'(active_regs), 128'h0);
      bus_read(9'h1F1, rd);
      check("idle_status", 128'(rd), 128'h0002_0000);

      // write without arm: no commit
      vcount = 10'd100;
      bus_write(9'd1, 32'hFFFF_FF64);
      bus_read(9'h1F1, rd);
      check("dirty_status", 128'(rd), 128'h0002_0002);
      vblank();
      check("noarm_active", 128'(active_regs), 128'h0);
      check("noarm_cd_cnt", 128'(cd_cnt), 128'd0);
`ifdef SHADOW_READBACK_EN
      bus_read(9'd1, rd);
      check("rb_pending1", 128'(rd), 128'h64);
`else
      bus_read(9'd1, rd);
      check("rb_pending1", 128'(rd), 128'h0);
`endif
      bus_read(9'h100, rd);
      check("unmapped_rd", 128'(rd), 128'h0);
      bus_write(9'h1F1, 32'h0);
      bus_read(9'h1F1, rd);
      check("status_after", 128'(rd), 128'h0003_0002);
      repeat (3) step();
      check("rd_hold", 128'(readdata), 128'h0003_0002);

      // armed commit with exact timing
      bus_write(9'h1F0, 32'h1);
      bus_read(9'h1F1, rd);
      check("armed_status", 128'(rd), 128'h0003_0003);
      vcount = 10'd480;
      step();
      check("fp_high", 128'(frame_pulse), 128'h1);
      check("pre_commit", 128'(active_regs), 128'h0);
      step();
      check("commit_active", 128'(active_regs), 128'h6400);
      check("commit_done", {127'h0, commit_done}, 128'h1);
      check("fp_low", 128'(frame_pulse), 128'h0);
      step();
      check("commit_done_drop", 128'(commit_done), 128'h0);
      vcount = 10'd0;
      step();
      check("arm_cd_cnt", 128'(cd_cnt), 128'd1);
      bus_read(9'h1F1, rd);
      check("post_commit_st", 128'(rd), 128'h0004_0000);
`ifdef SHADOW_READBACK_EN
      bus_read(9'h1F3, rd);
      check("rb_active1", 128'(rd), 128'h64);
`endif

      // auto mode
      bus_write(9'h1F0, 32'h2);
      bus_write(9'd10, 32'h07);
      bus_read(9'h1F1, rd);
      check("auto_status", 128'(rd), 128'h0004_0006);
      vblank();
      check("auto_active", 128'(active_regs), (128'h07 << 80) | 128'h6400);
      check("auto_cd_cnt", 128'(cd_cnt), 128'd2);
      vblank();
      check("auto_idle_cd", 128'(cd_cnt), 128'd2);
      bus_write(9'h1F0, 32'h0);
      bus_read(9'h1F1, rd);
      check("auto_off_st", 128'(rd), 128'h0006_0000);

      // pending write on the commit cycle
      bus_write(9'd0, 32'h10);
      bus_write(9'h1F0, 32'h1);
      vcount = 10'd480;
      step();
      check("sim_fp", 128'(frame_pulse), 128'h1);
      bus_write(9'd0, 32'h20);
      check("sim_active", 128'(active_regs), (128'h07 << 80) | 128'h6410);
      vcount = 10'd0;
      step();
      bus_read(9'h1F1, rd);
      check("sim_status", 128'(rd), 128'h0007_0002);
      bus_write(9'h1F0, 32'h1);
      vblank();
      check("sim_next", 128'(active_regs), (128'h07 << 80) | 128'h6420);
      check("sim_cd_cnt", 128'(cd_cnt), 128'd4);

      // mid-frame reset discards pending state
      vcount = 10'd300;
      bus_write(9'd2, 32'h55);
      bus_write(9'h1F0, 32'h1);
      bus_read(9'h1F1, rd);
      reset = 1'b1;
      repeat (2) step();
      check("mrst_active", 128'(active_regs), 128'h0);
      check("mrst_readdata", 128'(readdata), 128'h0);
      check("mrst_pulses", {126'h0, frame_pulse, commit_done}, 128'h0);
      reset = 1'b0;
      step();
      bus_read(9'h1F1, rd);
      check("mrst_status", 128'(rd), 128'h0);
      bus_write(9'h1F0, 32'h1);
      vblank();
      check("mrst_commit", 128'(active_regs), 128'h0);
      check("mrst_cd_cnt", 128'(cd_cnt), 128'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
